// File: rtl/mmio_arbiter.sv
// mmio_arbiter: round-robin sharing of the MMIO controller bus with even/odd pair-write locking,
// lock timeout and out-of-range rejection.
module mmio_arbiter #(
  parameter int REQ_COUNT     = 2,
  parameter int PORT_EXPONENT = 3,
  parameter int LOCK_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REQ_COUNT-1:0]    req_valid,
  input  logic [REQ_COUNT-1:0]    req_write,
  input  logic [REQ_COUNT*16-1:0] req_addr,
  input  logic [REQ_COUNT*16-1:0] req_wdata,
  output logic [REQ_COUNT-1:0]    req_gnt,
  output logic [REQ_COUNT-1:0]    rsp_valid,
  output logic [REQ_COUNT-1:0]    rsp_err,
  output logic [15:0]             rsp_rdata,
  output logic                    mmio_read,
  output logic                    mmio_write,
  output logic [15:0]             mmio_addr,
  output logic [15:0]             mmio_d_in,
  input  logic [15:0]             mmio_d_out,
  output logic                    lock_active,
  output logic                    lock_timeout
);
  localparam int IW = REQ_COUNT > 1 ? $clog2(REQ_COUNT) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [16:0] LIMIT = 17'(2 ** (PORT_EXPONENT + 1));
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr, owner, sel;
  logic [CW-1:0] cnt;
  logic any, in_range, sel_write, rd_pend;
  logic [15:0] sel_addr, sel_wdata;
  // While locked only the owner may be granted; otherwise scan from the rr pointer.
  always_comb begin
    any = 1'b0;
    sel = '0;
    if (state == LOCKED) begin
      any = req_valid[owner];
      sel = owner;
    end else
      for (int k = 0; k < REQ_COUNT; k++)
        if (!any && req_valid[(int'(rr) + k) % REQ_COUNT]) begin
          any = 1'b1;
          sel = IW'((int'(rr) + k) % REQ_COUNT);
        end
  end
  assign sel_addr    = req_addr[16*int'(sel) +: 16];
  assign sel_wdata   = req_wdata[16*int'(sel) +: 16];
  assign sel_write   = req_write[sel];
  assign in_range    = {1'b0, sel_addr} < LIMIT;
  assign req_gnt     = any ? REQ_COUNT'(1) << sel : '0;
  assign mmio_read   = any && !sel_write && in_range;
  assign mmio_write  = any && sel_write && in_range;
  assign mmio_addr   = any ? sel_addr : '0;
  assign mmio_d_in   = any ? sel_wdata : '0;
  assign lock_active = state == LOCKED;
  assign rsp_rdata   = rd_pend ? mmio_d_out : '0;
  always_comb begin
    state_nx     = state;
    lock_timeout = 1'b0;
    if (state == IDLE)
      state_nx = mmio_write && !sel_addr[0] ? LOCKED : IDLE;
    else if (mmio_write && sel_addr[0])
      state_nx = IDLE;
    else if (!any && cnt == CW'(1)) begin
      state_nx     = IDLE;
      lock_timeout = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      owner     <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rd_pend   <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= req_gnt;
      rsp_err   <= in_range ? '0 : req_gnt;
      rd_pend   <= mmio_read;
      if (any) rr <= sel == IW'(REQ_COUNT - 1) ? '0 : sel + IW'(1);
      if (state == IDLE && state_nx == LOCKED) owner <= sel;
      if (any) cnt <= CW'(LOCK_TIMEOUT);
      else if (state == LOCKED) cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: scenario tasks with a response scoreboard fed at grant time.
module tb_mmio_arbiter;
  localparam int N = 2, PE = 3, LT = 4;
  typedef struct packed {logic [N-1:0] v; logic [N-1:0] e; logic [15:0] d;} rsp_t;
  logic clk = 1'b0, rst_n;
  logic [N-1:0] req_valid, req_write, req_gnt, rsp_valid, rsp_err;
  logic [N*16-1:0] req_addr, req_wdata;
  logic [15:0] rsp_rdata, mmio_addr, mmio_d_in, mmio_d_out;
  logic mmio_read, mmio_write, lock_active, lock_timeout;
  int vecs = 0, errs = 0;
  rsp_t sb[$];
  logic [15:0] wlog[$];
  rsp_t m_exp, m_new;
  logic [15:0] m_a;
  logic m_er;

  mmio_arbiter #(.REQ_COUNT(N), .PORT_EXPONENT(PE), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
    .mmio_d_in(mmio_d_in), .mmio_d_out(mmio_d_out),
    .lock_active(lock_active), .lock_timeout(lock_timeout));

  always #5 clk = ~clk;

  // MMIO controller model: read data appears the cycle after the strobe.
  always @(posedge clk) mmio_d_out <= mmio_read ? 16'hBEEC + mmio_addr : 16'h5A5A;

  always @(negedge clk) begin
    if (rst_n) begin
      vecs++;
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL rsp_unexpected got valid=%b err=%b rdata=%h", rsp_valid, rsp_err, rsp_rdata);
        end else begin
          m_exp = sb.pop_front();
          if ({rsp_valid, rsp_err, rsp_rdata} !== m_exp) begin
            errs++;
            $display("FAIL rsp_scoreboard got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                     rsp_valid, rsp_err, rsp_rdata, m_exp.v, m_exp.e, m_exp.d);
          end
        end
      end else if (rsp_rdata !== 16'h0) begin
        errs++;
        $display("FAIL rsp_rdata_idle got %h exp 0000", rsp_rdata);
      end
      for (int i = 0; i < N; i++)
        if (req_gnt[i]) begin
          m_a   = req_addr[16*i +: 16];
          m_er  = m_a >= 16'(1 << (PE + 1));
          m_new.v = N'(1) << i;
          m_new.e = m_er ? N'(1) << i : '0;
          m_new.d = (req_write[i] || m_er) ? 16'h0 : 16'hBEEC + m_a;
          sb.push_back(m_new);
        end
      if (mmio_write) wlog.push_back(mmio_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[16*i +: 16] = a;
    req_wdata[16*i +: 16] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    #2;
    vecs++;
    if ({req_gnt, rsp_valid, rsp_err, rsp_rdata, mmio_read, mmio_write, mmio_addr, mmio_d_in, lock_active, lock_timeout} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got gnt=%b rv=%b re=%b rd=%h r=%b w=%b a=%h lk=%b to=%b exp all 0",
               req_gnt, rsp_valid, rsp_err, rsp_rdata, mmio_read, mmio_write, mmio_addr, lock_active, lock_timeout);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    tick(); set_req(0, 1, 0, 16'd3, 16'h0);
    @(negedge clk); vecs++;
    if ({req_gnt, mmio_read, mmio_write, mmio_addr} !== {2'b01, 1'b1, 1'b0, 16'd3}) begin
      errs++; $display("FAIL single_read_issue got gnt=%b r=%b w=%b a=%h exp 01 1 0 0003", req_gnt, mmio_read, mmio_write, mmio_addr);
    end
    tick(); set_req(0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); vecs++;
    if ({rsp_valid, rsp_err, rsp_rdata, req_gnt} !== {2'b01, 2'b00, 16'hBEEF, 2'b00}) begin
      errs++; $display("FAIL single_read_rsp got v=%b e=%b d=%h gnt=%b exp 01 00 beef 00", rsp_valid, rsp_err, rsp_rdata, req_gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g, prev_g;
    tick(); set_req(0, 1, 0, 16'd1, 16'h0); set_req(1, 1, 0, 16'd2, 16'h0);
    prev_g = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_g = c % 2 == 0 ? 2'b10 : 2'b01;
      vecs++;
      if (req_gnt !== exp_g) begin
        errs++; $display("FAIL rr_grant cycle %0d got %b exp %b", c, req_gnt, exp_g);
      end
      if (c > 0) begin
        vecs++;
        if (rsp_valid !== prev_g) begin
          errs++; $display("FAIL rr_rsp cycle %0d got %b exp %b", c, rsp_valid, prev_g);
        end
      end
      prev_g = exp_g;
      tick();
    end
    set_req(0, 0, 0, 16'h0, 16'h0); set_req(1, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_pair_lock();
    logic [15:0] exp_w[4] = '{16'd4, 16'd5, 16'd6, 16'd7};
    wlog.delete();
    tick(); set_req(0, 1, 1, 16'd4, 16'h1111);
    @(negedge clk); vecs++;
    if ({req_gnt, mmio_write, mmio_addr, mmio_d_in, lock_active} !== {2'b01, 1'b1, 16'd4, 16'h1111, 1'b0}) begin
      errs++; $display("FAIL lock_first got gnt=%b w=%b a=%h d=%h lk=%b", req_gnt, mmio_write, mmio_addr, mmio_d_in, lock_active);
    end
    tick(); set_req(0, 0, 0, 16'h0, 16'h0); set_req(1, 1, 1, 16'd6, 16'h3333);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); vecs++;
      if ({req_gnt, mmio_write, lock_active} !== {2'b00, 1'b0, 1'b1}) begin
        errs++; $display("FAIL lock_hold cycle %0d got gnt=%b w=%b lk=%b exp 00 0 1", c, req_gnt, mmio_write, lock_active);
      end
      tick();
    end
    set_req(0, 1, 1, 16'd5, 16'h2222);
    @(negedge clk); vecs++;
    if ({req_gnt, mmio_addr, mmio_d_in, lock_active} !== {2'b01, 16'd5, 16'h2222, 1'b1}) begin
      errs++; $display("FAIL lock_second got gnt=%b a=%h d=%h lk=%b", req_gnt, mmio_addr, mmio_d_in, lock_active);
    end
    tick(); set_req(0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); vecs++;
    if ({req_gnt, mmio_addr, lock_active} !== {2'b10, 16'd6, 1'b0}) begin
      errs++; $display("FAIL lock_release got gnt=%b a=%h lk=%b exp 10 0006 0", req_gnt, mmio_addr, lock_active);
    end
    tick(); set_req(1, 1, 1, 16'd7, 16'h4444);
    @(negedge clk); vecs++;
    if ({req_gnt, lock_active} !== {2'b10, 1'b1}) begin
      errs++; $display("FAIL lock_owner1 got gnt=%b lk=%b exp 10 1", req_gnt, lock_active);
    end
    tick(); set_req(1, 0, 0, 16'h0, 16'h0);
    @(negedge clk); vecs++;
    if (lock_active !== 1'b0) begin
      errs++; $display("FAIL lock_owner1_release got lk=%b exp 0", lock_active);
    end
    vecs++;
    if (wlog.size() != 4) begin
      errs++; $display("FAIL write_order_len got %0d exp 4", wlog.size());
    end else
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (wlog[i] !== exp_w[i]) begin
          errs++; $display("FAIL write_order[%0d] got %h exp %h", i, wlog[i], exp_w[i]);
        end
      end
  endtask

  task automatic test_timeout();
    tick(); set_req(0, 1, 1, 16'd2, 16'hABCD);
    @(negedge clk); vecs++;
    if ({req_gnt, lock_timeout} !== {2'b01, 1'b0}) begin
      errs++; $display("FAIL to_lock got gnt=%b to=%b exp 01 0", req_gnt, lock_timeout);
    end
    tick(); set_req(0, 0, 0, 16'h0, 16'h0); set_req(1, 1, 0, 16'd0, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); vecs++;
      if ({req_gnt, lock_active, lock_timeout} !== {2'b00, 1'b1, c == 4}) begin
        errs++; $display("FAIL to_wait cycle %0d got gnt=%b lk=%b to=%b exp 00 1 %0d", c, req_gnt, lock_active, lock_timeout, c == 4);
      end
      tick();
    end
    @(negedge clk); vecs++;
    if ({req_gnt, lock_active, lock_timeout, mmio_read} !== {2'b10, 1'b0, 1'b0, 1'b1}) begin
      errs++; $display("FAIL to_after got gnt=%b lk=%b to=%b r=%b exp 10 0 0 1", req_gnt, lock_active, lock_timeout, mmio_read);
    end
    tick(); set_req(1, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_out_of_range();
    tick(); set_req(1, 1, 0, 16'h0010, 16'h0);
    @(negedge clk); vecs++;
    if ({req_gnt, mmio_read, mmio_write, mmio_addr} !== {2'b10, 1'b0, 1'b0, 16'h0010}) begin
      errs++; $display("FAIL oor_issue got gnt=%b r=%b w=%b a=%h exp 10 0 0 0010", req_gnt, mmio_read, mmio_write, mmio_addr);
    end
    tick(); set_req(1, 0, 0, 16'h0, 16'h0); set_req(0, 1, 0, 16'h000F, 16'h0);
    @(negedge clk); vecs++;
    if ({rsp_valid, rsp_err, rsp_rdata, req_gnt, mmio_read} !== {2'b10, 2'b10, 16'h0, 2'b01, 1'b1}) begin
      errs++; $display("FAIL oor_rsp got v=%b e=%b d=%h gnt=%b r=%b exp 10 10 0000 01 1", rsp_valid, rsp_err, rsp_rdata, req_gnt, mmio_read);
    end
    tick(); set_req(0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); vecs++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 2'b00, 16'hBEFB}) begin
      errs++; $display("FAIL edge_addr_rsp got v=%b e=%b d=%h exp 01 00 befb", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_lock();
    tick(); set_req(1, 1, 1, 16'd8, 16'h5555);
    @(negedge clk); vecs++;
    if (req_gnt !== 2'b10) begin
      errs++; $display("FAIL rml_lock got gnt=%b exp 10", req_gnt);
    end
    tick(); set_req(1, 1, 0, 16'd9, 16'h0);
    @(negedge clk); vecs++;
    if ({req_gnt, lock_active} !== {2'b10, 1'b1}) begin
      errs++; $display("FAIL rml_read got gnt=%b lk=%b exp 10 1", req_gnt, lock_active);
    end
    tick(); vecs++;
    if (rsp_valid !== 2'b10) begin
      errs++; $display("FAIL rml_pending got %b exp 10", rsp_valid);
    end
    set_req(1, 0, 0, 16'h0, 16'h0);
    rst_n = 1'b0;
    #1; vecs++;
    if ({lock_active, rsp_valid, lock_timeout} !== '0) begin
      errs++; $display("FAIL rml_async got lk=%b v=%b to=%b exp 0 00 0", lock_active, rsp_valid, lock_timeout);
    end
    sb.delete();
    tick(); rst_n = 1'b1;
    tick(); set_req(0, 1, 0, 16'd1, 16'h0); set_req(1, 1, 0, 16'd2, 16'h0);
    @(negedge clk); vecs++;
    if (req_gnt !== 2'b01) begin
      errs++; $display("FAIL rml_first got gnt=%b exp 01", req_gnt);
    end
    tick(); set_req(0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); vecs++;
    if (req_gnt !== 2'b10) begin
      errs++; $display("FAIL rml_second got gnt=%b exp 10", req_gnt);
    end
    tick(); set_req(1, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_pair_lock();
    test_timeout();
    test_out_of_range();
    test_reset_mid_lock();
    vecs++;
    if (sb.size() != 0) begin
      errs++; $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
